// File: rtl/segment_rule_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : segment_rule_scan_pkg
// Desc     : Shared widths, rule-entry layout and FSM encoding for the
//            segment rule scan stage.
// Revision : 1.0 - initial release
// ============================================================================
package segment_rule_scan_pkg;

    localparam int TUPLE_W     = 104;
    localparam int ID_W        = 16;
    localparam int SEG_IDX_W   = 11;
    localparam int ADDR_W      = 16;
    localparam int SMALL_SLOTS = 4;
    localparam int BIG_SLOTS   = 16;
    localparam int BIG_BASE    = 8192;
    localparam int SLOT_W      = $clog2(BIG_SLOTS);
    localparam int RULE_W      = 1 + ID_W + 2 * TUPLE_W;

    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    rule_id;
        logic [TUPLE_W-1:0] mask;
        logic [TUPLE_W-1:0] value;
    } rule_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    // Small segments sit at the bottom of rule memory, big ones above BIG_BASE.
    function automatic logic [ADDR_W-1:0] seg_base(
        input logic                 big,
        input logic [SEG_IDX_W-1:0] idx
    );
        logic [ADDR_W-1:0] ext;
        logic [ADDR_W-1:0] base;
        ext = ADDR_W'(idx);
        if (big) begin
            base = ADDR_W'(BIG_BASE) + ext * ADDR_W'(BIG_SLOTS);
        end else begin
            base = ext * ADDR_W'(SMALL_SLOTS);
        end
        return base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/segment_rule_scan_match_cmp.sv
`default_nettype none
// ============================================================================
// Module   : rule_match_cmp
// Desc     : Combinational masked compare of one rule entry against a tuple.
// Revision : 1.0 - initial release
// ============================================================================
module rule_match_cmp
    import segment_rule_scan_pkg::*;
(
    input  logic [TUPLE_W-1:0] tuple,
    input  rule_entry_t        entry,
    output logic               hit
);

    assign hit = entry.valid && (((tuple ^ entry.value) & entry.mask) == '0);

endmodule
`default_nettype wire

// File: rtl/segment_rule_scan.sv
`default_nettype none
// ============================================================================
// Module   : segment_rule_scan
// Desc     : Walks every slot of a small/big rule segment and reports the
//            lowest-slot masked match. Optional SEG_SCAN_EARLY_EXIT_EN stops
//            the scan at the first hit.
// Revision : 1.0 - initial release
// ============================================================================
module segment_rule_scan
    import segment_rule_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TUPLE_W-1:0]   tupleData,
    input  logic                 smallorbig_segment,
    input  logic [SEG_IDX_W-1:0] seg_index,
    output logic                 rule_rd_en,
    output logic [ADDR_W-1:0]    rule_addr,
    input  logic [RULE_W-1:0]    rule_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_hit,
    output logic [ID_W-1:0]      out_rule_id
);

    state_t              r_state;
    logic [TUPLE_W-1:0]  r_tuple;
    logic                r_big;
    logic [SLOT_W-1:0]   r_slot;
    logic                r_data_vld;
    logic                r_hit;
    logic [ID_W-1:0]     r_id;

    rule_entry_t         w_entry;
    logic                w_cmp_hit;
    logic                w_new_hit;
    logic [SLOT_W-1:0]   w_last_slot;

    assign w_entry     = rule_rdata;
    assign w_last_slot = r_big ? SLOT_W'(BIG_SLOTS - 1) : SLOT_W'(SMALL_SLOTS - 1);
    // Only the first match of a scan counts; later ones are lower priority.
    assign w_new_hit   = r_data_vld && w_cmp_hit && !r_hit;

    rule_match_cmp u_cmp (
        .tuple (r_tuple),
        .entry (w_entry),
        .hit   (w_cmp_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tuple     <= '0;
            r_big       <= 1'b0;
            r_slot      <= '0;
            r_data_vld  <= 1'b0;
            r_hit       <= 1'b0;
            r_id        <= '0;
            in_ready    <= 1'b1;
            rule_rd_en  <= 1'b0;
            rule_addr   <= '0;
            out_valid   <= 1'b0;
            out_hit     <= 1'b0;
            out_rule_id <= '0;
        end else begin
            // Read data is valid exactly one cycle after the strobe.
            r_data_vld <= rule_rd_en;

            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_tuple    <= tupleData;
                        r_big      <= smallorbig_segment;
                        r_slot     <= '0;
                        r_hit      <= 1'b0;
                        r_id       <= '0;
                        rule_addr  <= seg_base(smallorbig_segment, seg_index);
                        rule_rd_en <= 1'b1;
                        in_ready   <= 1'b0;
                        r_state    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (w_new_hit) begin
                        r_hit <= 1'b1;
                        r_id  <= w_entry.rule_id;
                    end
`ifdef SEG_SCAN_EARLY_EXIT_EN
                    if (w_new_hit) begin
                        rule_rd_en  <= 1'b0;
                        out_valid   <= 1'b1;
                        out_hit     <= 1'b1;
                        out_rule_id <= w_entry.rule_id;
                        r_state     <= ST_RESULT;
                    end else
`endif
                    if (r_slot == w_last_slot) begin
                        rule_rd_en <= 1'b0;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_slot    <= r_slot + SLOT_W'(1);
                        rule_addr <= rule_addr + ADDR_W'(1);
                    end
                end

                ST_DRAIN: begin
                    // Last slot's data is being compared this cycle.
                    out_valid <= 1'b1;
                    out_hit   <= r_hit || w_new_hit;
                    if (r_hit) begin
                        out_rule_id <= r_id;
                    end else if (w_new_hit) begin
                        out_rule_id <= w_entry.rule_id;
                    end else begin
                        out_rule_id <= '0;
                    end
                    r_state <= ST_RESULT;
                end

                ST_RESULT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_hit     <= 1'b0;
                        out_rule_id <= '0;
                        in_ready    <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_segment_rule_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_rule_scan
// Desc     : Directed self-checking bench for segment_rule_scan with a
//            one-cycle-latency rule memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_rule_scan;
    import segment_rule_scan_pkg::*;

`ifdef SEG_SCAN_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    localparam logic [TUPLE_W-1:0] ONES = {TUPLE_W{1'b1}};
    localparam logic [TUPLE_W-1:0] ZERO = {TUPLE_W{1'b0}};
    localparam logic [TUPLE_W-1:0] DSTM = 104'h0000_0000_FFFF_FFFF_0000_0000_00;
    localparam logic [TUPLE_W-1:0] TA   = 104'h0A00_0001_0A00_0002_1F90_0050_06;
    localparam logic [TUPLE_W-1:0] TB   = 104'hC0A8_0101_C0A8_0202_D431_01BB_11;
    localparam logic [TUPLE_W-1:0] TC   = 104'h0102_0304_0506_0708_1234_5678_9A;
    // Returned whenever no read was issued: matches anything if wrongly used.
    localparam logic [RULE_W-1:0]  POISON = {1'b1, 16'hDEAD, ZERO, ZERO};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [TUPLE_W-1:0]   tupleData;
    logic                 smallorbig_segment;
    logic [SEG_IDX_W-1:0] seg_index;
    logic                 rule_rd_en;
    logic [ADDR_W-1:0]    rule_addr;
    logic [RULE_W-1:0]    rule_rdata;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_hit;
    logic [ID_W-1:0]      out_rule_id;

    logic [RULE_W-1:0]    mem [0:65535];
    logic [ADDR_W-1:0]    addr_log [$];
    int                   checks = 0;
    int                   errors = 0;

    segment_rule_scan dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .tupleData          (tupleData),
        .smallorbig_segment (smallorbig_segment),
        .seg_index          (seg_index),
        .rule_rd_en         (rule_rd_en),
        .rule_addr          (rule_addr),
        .rule_rdata         (rule_rdata),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_hit            (out_hit),
        .out_rule_id        (out_rule_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rule_rd_en) begin
            rule_rdata <= mem[rule_addr];
            addr_log.push_back(rule_addr);
        end else begin
            rule_rdata <= POISON;
        end
    end

    task automatic set_rule(input int a, input bit v, input logic [ID_W-1:0] id,
                            input logic [TUPLE_W-1:0] m, input logic [TUPLE_W-1:0] val);
        mem[a] = {v, id, m, val};
    endtask

    task automatic send_req(input bit big, input logic [SEG_IDX_W-1:0] idx,
                            input logic [TUPLE_W-1:0] t);
        @(negedge clk);
        in_valid = 1'b1; smallorbig_segment = big; seg_index = idx; tupleData = t;
        addr_log.delete();
        @(posedge clk);
    endtask

    // Returns the cycle number (T0+n) in which out_valid is first seen.
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
        end while (out_valid !== 1'b1 && cyc < 100);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic bit log_ok(input int base, input int n);
        bit ok;
        ok = (addr_log.size() == n);
        foreach (addr_log[i]) if (addr_log[i] !== 16'(base + i)) ok = 1'b0;
        return ok;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        smallorbig_segment = 1'b0; seg_index = '0; tupleData = '0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_hit !== 1'b0) begin errors++; $display("FAIL reset_out_hit: got %0b expected 0", out_hit); end
        checks++; if (out_rule_id !== 16'h0) begin errors++; $display("FAIL reset_rule_id: got %0h expected 0", out_rule_id); end
        checks++; if (rule_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", rule_rd_en); end
        checks++; if (rule_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", rule_addr); end
        rst = 1'b0;
    endtask

    task automatic test_small_hit();
        int cyc;
        set_rule(20, 1'b1, 16'h0011, ONES, TA ^ 104'h1);
        set_rule(21, 1'b1, 16'h0021, ONES, ZERO);
        set_rule(22, 1'b1, 16'h0042, ONES, TA);
        set_rule(23, 1'b1, 16'h0099, ZERO, ZERO);
        send_req(1'b0, 11'd5, TA);
        wait_out(cyc);
        checks++; if (cyc !== (EE ? 5 : 6)) begin errors++; $display("FAIL small_latency: got %0d expected %0d", cyc, EE ? 5 : 6); end
        checks++; if (out_hit !== 1'b1) begin errors++; $display("FAIL small_hit: got %0b expected 1", out_hit); end
        checks++; if (out_rule_id !== 16'h0042) begin errors++; $display("FAIL small_id: got %0h expected 0042", out_rule_id); end
        checks++; if (!log_ok(20, 4)) begin errors++; $display("FAIL small_addrs: got %0d reads expected 4 from 20", addr_log.size()); end
        handshake();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL small_release: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_big_multi();
        int cyc;
        set_rule(8240 + 3,  1'b1, 16'h0003, DSTM, 104'h1111_1111_C0A8_0203_2222_3333_44);
        set_rule(8240 + 5,  1'b0, 16'h0005, ZERO, TB);
        set_rule(8240 + 7,  1'b1, 16'h0007, DSTM, 104'h1111_1111_C0A8_0202_2222_3333_44);
        set_rule(8240 + 12, 1'b1, 16'h000C, ONES, TB);
        send_req(1'b1, 11'd3, TB);
        wait_out(cyc);
        checks++; if (cyc !== (EE ? 10 : 18)) begin errors++; $display("FAIL big_latency: got %0d expected %0d", cyc, EE ? 10 : 18); end
        checks++; if (out_hit !== 1'b1) begin errors++; $display("FAIL big_hit: got %0b expected 1", out_hit); end
        checks++; if (out_rule_id !== 16'h0007) begin errors++; $display("FAIL big_id: got %0h expected 0007", out_rule_id); end
        checks++; if (!log_ok(8240, EE ? 9 : 16)) begin errors++; $display("FAIL big_addrs: got %0d reads expected %0d from 8240", addr_log.size(), EE ? 9 : 16); end
        handshake();
    endtask

    task automatic test_no_hit();
        int cyc;
        for (int i = 0; i < 4; i++) set_rule(i, 1'b0, 16'h00F0 + 16'(i), ZERO, TA);
        send_req(1'b0, 11'd0, TA);
        wait_out(cyc);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL nohit_latency: got %0d expected 6", cyc); end
        checks++; if (out_hit !== 1'b0) begin errors++; $display("FAIL nohit_hit: got %0b expected 0", out_hit); end
        checks++; if (out_rule_id !== 16'h0) begin errors++; $display("FAIL nohit_id: got %0h expected 0", out_rule_id); end
        checks++; if (!log_ok(0, 4)) begin errors++; $display("FAIL nohit_addrs: got %0d reads expected 4 from 0", addr_log.size()); end
        handshake();
    endtask

    task automatic test_backpressure();
        int cyc;
        set_rule(36, 1'b1, 16'h0901, ONES, TB);
        set_rule(40, 1'b1, 16'h0A00, ONES, TB);
        set_rule(43, 1'b1, 16'h0A03, ZERO, ZERO);
        send_req(1'b0, 11'd9, TB);
        wait_out(cyc);
        checks++; if (out_hit !== 1'b1 || out_rule_id !== 16'h0901) begin errors++; $display("FAIL bp_first: got hit=%0b id=%0h expected 1/0901", out_hit, out_rule_id); end
        in_valid = 1'b1; smallorbig_segment = 1'b0; seg_index = 11'd10; tupleData = TC;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_hit !== 1'b1 || out_rule_id !== 16'h0901 ||
                in_ready !== 1'b0 || rule_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%0b hit=%0b id=%0h rdy=%0b rd=%0b expected 1/1/0901/0/0",
                         k, out_valid, out_hit, out_rule_id, in_ready, rule_rd_en);
            end
        end
        handshake();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid); end
        addr_log.delete();
        @(posedge clk);
        wait_out(cyc);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL bp_second_latency: got %0d expected 6", cyc); end
        checks++; if (out_hit !== 1'b1 || out_rule_id !== 16'h0A03) begin errors++; $display("FAIL bp_second: got hit=%0b id=%0h expected 1/0a03", out_hit, out_rule_id); end
        checks++; if (!log_ok(40, 4)) begin errors++; $display("FAIL bp_second_addrs: got %0d reads expected 4 from 40", addr_log.size()); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit quiet;
        set_rule(8208 + 0, 1'b1, 16'hBAD0, ZERO, ZERO);
        set_rule(8208 + 2, 1'b1, 16'hBAD2, ZERO, ZERO);
        set_rule(48, 1'b1, 16'h0C00, ONES, TB);
        set_rule(49, 1'b1, 16'h0C01, ZERO, ZERO);
        send_req(1'b1, 11'd1, TA);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (k == 3) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || rule_rd_en !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got rdy=%0b rd=%0b v=%0b expected 1/0/0", in_ready, rule_rd_en, out_valid); end
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || rule_rd_en !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL rstmid_quiet: got activity after reset expected none"); end
        send_req(1'b0, 11'd12, TA);
        wait_out(cyc);
        checks++; if (cyc !== (EE ? 4 : 6)) begin errors++; $display("FAIL rstmid_latency: got %0d expected %0d", cyc, EE ? 4 : 6); end
        checks++; if (out_hit !== 1'b1 || out_rule_id !== 16'h0C01) begin errors++; $display("FAIL rstmid_result: got hit=%0b id=%0h expected 1/0c01", out_hit, out_rule_id); end
        checks++; if (!log_ok(48, EE ? 3 : 4)) begin errors++; $display("FAIL rstmid_addrs: got %0d reads expected %0d from 48", addr_log.size(), EE ? 3 : 4); end
        handshake();
    endtask

    task automatic test_slot0_hit();
        int cyc;
        set_rule(8352 + 0, 1'b1, 16'h1234, DSTM, TC);
        set_rule(8352 + 1, 1'b1, 16'h5555, ZERO, ZERO);
        send_req(1'b1, 11'd10, TC);
        wait_out(cyc);
        checks++; if (cyc !== (EE ? 3 : 18)) begin errors++; $display("FAIL slot0_latency: got %0d expected %0d", cyc, EE ? 3 : 18); end
        checks++; if (out_hit !== 1'b1 || out_rule_id !== 16'h1234) begin errors++; $display("FAIL slot0_result: got hit=%0b id=%0h expected 1/1234", out_hit, out_rule_id); end
        checks++; if (!log_ok(8352, EE ? 2 : 16)) begin errors++; $display("FAIL slot0_addrs: got %0d reads expected %0d from 8352", addr_log.size(), EE ? 2 : 16); end
        @(negedge clk);
        checks++; if (rule_rd_en !== 1'b0 || out_rule_id !== 16'h1234) begin errors++; $display("FAIL slot0_settle: got rd=%0b id=%0h expected 0/1234", rule_rd_en, out_rule_id); end
        handshake();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        test_reset();
        test_small_hit();
        test_big_multi();
        test_no_hit();
        test_backpressure();
        test_reset_mid();
        test_slot0_hit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
